// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program load port, run control, and the IF/ID register fields
// handed to the decoder.
interface instruction_fetch_if #(
  parameter int PC_W = 5
);
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [15:0]     load_data;
  logic            start;
  logic            stall;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [2:0]      if_opcode;
  logic [2:0]      if_rd;
  logic [2:0]      if_rs;
  logic [2:0]      if_rt;
  logic [6:0]      if_imm;
  logic            busy;
  logic            halted;

  modport master (
    output load_en, load_addr, load_data, start, stall,
    input  if_valid, if_pc, if_opcode, if_rd, if_rs, if_rt, if_imm, busy, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stall,
    output if_valid, if_pc, if_opcode, if_rd, if_rs, if_rt, if_imm, busy, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: loadable instruction memory, program counter and the
// IF/ID pipeline register, with HALT / end-of-memory detection and stall support.
module instruction_fetch #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = 5
) (
  input logic                clk,
  input logic                rst,
  instruction_fetch_if.slave bus
);
  localparam int              INST_W  = 16;
  localparam logic [2:0]      OP_HALT = 3'd7;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   if_pc_reg;
  logic [INST_W-1:0] ir_reg;
  logic              if_valid_reg;
  logic [INST_W-1:0] mem_reg [IMEM_DEPTH];
  logic [INST_W-1:0] fetch_word;

  // Combinational read so the word at PC is registered straight into IF/ID.
  assign fetch_word = mem_reg[pc_reg];

  // Memory is not cleared by reset; writes are only accepted while idle.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.load_en) begin
      mem_reg[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      if_pc_reg    <= '0;
      ir_reg       <= '0;
      if_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            pc_reg    <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (fetch_word[15:13] == OP_HALT) begin
              // The HALT word itself is never presented downstream.
              if_valid_reg <= 1'b0;
              state_reg    <= HALT;
            end else begin
              ir_reg       <= fetch_word;
              if_pc_reg    <= pc_reg;
              if_valid_reg <= 1'b1;
              if (pc_reg == PC_LAST) begin
                state_reg <= HALT;
              end else begin
                pc_reg <= pc_reg + PC_W'(1);
              end
            end
          end
        end
        HALT: begin
          if_valid_reg <= 1'b0;
          if (bus.start) begin
            pc_reg    <= '0;
            state_reg <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.if_valid  = if_valid_reg;
  assign bus.if_pc     = if_pc_reg;
  assign bus.if_opcode = ir_reg[15:13];
  assign bus.if_rd     = ir_reg[12:10];
  assign bus.if_rs     = ir_reg[9:7];
  assign bus.if_rt     = ir_reg[6:4];
  assign bus.if_imm    = ir_reg[6:0];
  assign bus.busy      = (state_reg == RUN);
  assign bus.halted    = (state_reg == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: expected fetch streams are derived from a
// shadow copy of the program (scan from 0 to HALT or the last address).
module tb_instruction_fetch;
  localparam int PC_W  = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(.PC_W(PC_W)) bus ();

  instruction_fetch #(.IMEM_DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] mem_model [DEPTH];

  function automatic logic [15:0] obs_word();
    return {bus.if_opcode, bus.if_rd, bus.if_rs, bus.if_imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] op);
    return {op, 3'($urandom), 3'($urandom), 3'($urandom), 4'b0000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [6:0] imm);
    return {op, 3'($urandom), 3'($urandom), imm};
  endfunction

  function automatic logic [15:0] random_word();
    logic [2:0] op;
    op = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    return {op, 13'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_word(input int addr, input logic [15:0] data);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_addr = PC_W'(addr);
    bus.load_data = data;
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
    mem_model[addr] = data;
  endtask

  // Starts a run (optionally with a same-cycle load) and follows it to HALT.
  task automatic exec_program(input string tag, input int stall_pct, input logic [63:0] stall_mask,
                              input bit junk, input bit co_load, input int co_addr,
                              input logic [15:0] co_data);
    logic [15:0]     exp_word [$];
    logic [PC_W-1:0] exp_pc [$];
    logic [15:0]     held_word;
    logic [PC_W-1:0] held_pc;
    logic            held_valid;
    bit              ends_last, done, s, in_run;
    int              idx;

    @(negedge clk);
    bus.start = 1'b1;
    if (co_load) begin
      bus.load_en   = 1'b1;
      bus.load_addr = PC_W'(co_addr);
      bus.load_data = co_data;
      mem_model[co_addr] = co_data;
    end
    ends_last = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem_model[a][15:13] == 3'd7) break;
      exp_word.push_back(mem_model[a]);
      exp_pc.push_back(PC_W'(a));
      if (a == DEPTH - 1) ends_last = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.halted !== 1'b0 || bus.if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start_entry: busy=%b halted=%b valid=%b, required 1 0 0",
               tag, bus.busy, bus.halted, bus.if_valid);
    end
    held_word  = obs_word();
    held_pc    = bus.if_pc;
    held_valid = bus.if_valid;
    idx  = 0;
    done = 1'b0;
    for (int k = 1; k < 400 && !done; k++) begin
      in_run = !(ends_last && idx == exp_word.size());
      @(negedge clk);
      s = (k < 64 && stall_mask[k]) || ($urandom_range(0, 99) < stall_pct);
      bus.stall = s;
      if (junk && in_run) begin
        bus.load_en   = 1'($urandom_range(0, 1));
        bus.load_addr = PC_W'($urandom);
        bus.load_data = {3'd7, 13'($urandom)};
        bus.start     = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      bus.stall   = 1'b0;
      bus.load_en = 1'b0;
      bus.start   = 1'b0;
      if (s && in_run) begin
        vectors++;
        if (bus.if_valid !== held_valid || bus.if_pc !== held_pc || obs_word() !== held_word ||
            bus.busy !== 1'b1 || bus.halted !== 1'b0) begin
          miscompares++;
          $display("FAIL %s stall_hold: valid=%b pc=%0d word=%h busy=%b, required %b %0d %h 1",
                   tag, bus.if_valid, bus.if_pc, obs_word(), bus.busy, held_valid, held_pc, held_word);
        end
      end else if (idx < exp_word.size()) begin
        vectors++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc[idx] || obs_word() !== exp_word[idx] ||
            bus.if_rt !== exp_word[idx][6:4]) begin
          miscompares++;
          $display("FAIL %s fetch: valid=%b pc=%0d word=%h rt=%0d, required 1 %0d %h %0d",
                   tag, bus.if_valid, bus.if_pc, obs_word(), bus.if_rt, exp_pc[idx],
                   exp_word[idx], exp_word[idx][6:4]);
        end
        vectors++;
        if (bus.halted !== (ends_last && idx == exp_word.size() - 1)) begin
          miscompares++;
          $display("FAIL %s halted_flag: halted=%b at pc %0d, required %b",
                   tag, bus.halted, exp_pc[idx], (ends_last && idx == exp_word.size() - 1));
        end
        $display("[%s] pc=%0d op=%0d word=%h", tag, bus.if_pc, bus.if_opcode, obs_word());
        held_word  = obs_word();
        held_pc    = bus.if_pc;
        held_valid = bus.if_valid;
        idx++;
      end else begin
        vectors++;
        if (bus.if_valid !== 1'b0 || bus.halted !== 1'b1 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s end: valid=%b halted=%b busy=%b, required 0 1 0",
                   tag, bus.if_valid, bus.halted, bus.busy);
        end
        $display("[%s] halted after %0d instructions", tag, idx);
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: emitted %0d, required %0d then halt", tag, idx, exp_word.size());
    end
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.if_valid !== 1'b0 ||
        bus.if_pc !== '0 || obs_word() !== 16'h0000 || bus.if_rt !== 3'd0) begin
      miscompares++;
      $display("FAIL %s idle_state: busy=%b halted=%b valid=%b pc=%0d word=%h, required all zero",
               tag, bus.busy, bus.halted, bus.if_valid, bus.if_pc, obs_word());
    end
    $display("[%s] idle state observed", tag);
  endtask

  task automatic load_basic();
    do_reset();
    load_word(0, enc_r(3'd0));
    load_word(1, enc_i(3'd1, 7'd5));
    load_word(2, enc_r(3'd2));
    load_word(3, enc_r(3'd3));
    load_word(4, enc_r(3'd4));
    load_word(5, {3'd7, 13'd0});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    for (int a = 0; a < DEPTH; a++) load_word(a, random_word());
  endtask

  task automatic test_basic_program();
    load_basic();
    exec_program("basic", 0, 64'h0, 1'b0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_stall();
    load_basic();
    exec_program("stall3", 0, 64'h70, 1'b0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_reset_midrun();
    bit seen = 1'b0;
    load_basic();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.if_valid === 1'b1 && bus.if_pc === PC_W'(3)) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midrun_reach_pc3: pc=%0d valid=%b, required pc 3 valid 1", bus.if_pc, bus.if_valid);
    end
    do_reset();
    check_idle("midrun_reset");
    exec_program("after_reset", 0, 64'h0, 1'b0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_load_during_run();
    load_basic();
    exec_program("load_in_run", 20, 64'h0, 1'b1, 1'b0, 0, 16'h0);
  endtask

  task automatic test_restart_from_halt();
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = {3'd7, 13'd0};
    bus.stall     = 1'b1;
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
    bus.stall   = 1'b0;
    vectors++;
    if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_hold: halted=%b valid=%b busy=%b, required 1 0 0",
               bus.halted, bus.if_valid, bus.busy);
    end
    exec_program("restart", 0, 64'h0, 1'b0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_full_memory();
    do_reset();
    for (int a = 0; a < DEPTH; a++) load_word(a, enc_r(3'd0));
    exec_program("full", 0, 64'h0, 1'b0, 1'b0, 0, 16'h0);
    exec_program("full_stall", 25, 64'h0, 1'b1, 1'b0, 0, 16'h0);
  endtask

  task automatic test_random_programs();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int a = 0; a < DEPTH; a++) load_word(a, random_word());
      exec_program("random", 30, 64'h0, 1'b1, 1'b0, 0, 16'h0);
      exec_program("random_again", 0, 64'h0, 1'b0, 1'b0, 0, 16'h0);
    end
  endtask

  task automatic test_start_with_load();
    load_basic();
    exec_program("start_load", 0, 64'h0, 1'b0, 1'b1, 0, enc_r(3'd4));
    vectors++;
    if (mem_model[0][15:13] !== 3'd4) begin
      miscompares++;
      $display("FAIL start_load_model: op=%0d, required 4", mem_model[0][15:13]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    test_reset();
    test_basic_program();
    test_stall();
    test_reset_midrun();
    test_load_during_run();
    test_restart_from_halt();
    test_full_memory();
    test_random_programs();
    test_start_with_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the five-opcode pipelined core; it sits directly upstream of the instruction decoder. It holds a loadable instruction memory and a program counter, and registers each fetched word into the IF/ID pipeline register. Its 3-bit opcode output drives the decoder's `inst` input. It also detects program end (HALT opcode or last address) and supports a stall input from downstream hazard logic.

## Interface
- `IMEM_DEPTH`, default 32: number of instruction words; must equal 2**`PC_W`.
- `PC_W`, default 5: program counter width.
- `INST_W`, fixed 16: instruction width. Fields: op[15:13], rd[12:10], rs[9:7], rt[6:4], imm[6:0]; rt and imm overlap.
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `load_en` in, 1 bit: instruction memory write strobe; honoured only in IDLE.
- `load_addr` in, `PC_W` bits: write address.
- `load_data` in, 16 bits: write data.
- `start` in, 1 bit: pulse that begins execution at PC 0; honoured in IDLE and HALT.
- `stall` in, 1 bit: holds PC and the IF/ID register.
- `if_valid` out, 1 bit: the IF/ID register holds a real instruction.
- `if_pc` out, `PC_W` bits: address of the held instruction.
- `if_opcode` out, 3 bits: op field; connects to the decoder's `inst`.
- `if_rd`, `if_rs`, `if_rt` out, 3 bits each: register fields.
- `if_imm` out, 7 bits: raw immediate, not extended.
- `busy` out, 1 bit: state is RUN.
- `halted` out, 1 bit: state is HALT.

## Operation
- Opcodes: ADD=0, ADDI=1, SW=2, LW=3, SLL=4; 5 and 6 are reserved and pass through unchanged; 7 is HALT.
- Memory: register array with a combinational read at PC and a synchronous write. Contents are not cleared by reset.
- States: IDLE, RUN, HALT.
- IDLE:
  - `load_en` writes `load_data` to `load_addr`.
  - `start` sets PC to 0 and moves to RUN.
  - If `start` and `load_en` occur in the same cycle, both take effect; the written word is visible to the first fetch.
- RUN, with `stall`=0, on each edge:
  - If op(imem[PC]) is 7: `if_valid`<=0, PC holds, move to HALT. The HALT word is never emitted.
  - Otherwise: IF/ID <= imem[PC], `if_pc`<=PC, `if_valid`<=1.
  - Then, if PC equals `IMEM_DEPTH`-1: PC holds and the state moves to HALT. There is no wrap-around.
  - Else PC<=PC+1.
- RUN, with `stall`=1: PC, the IF/ID register, `if_valid` and the state all hold. HALT detection is deferred until the stall is released.
- RUN ignores `load_en` and `start`.
- HALT:
  - `if_valid` is 0.
  - `load_en` is ignored; return to IDLE only through `rst`.
  - `start` restarts at PC 0 and moves to RUN, with memory intact.
  - `stall` has no effect.
- Reset, from any state including mid-run:
  - state=IDLE, PC=0.
  - `if_valid`=0, `if_pc`=0, all field outputs 0.
  - `busy`=0, `halted`=0.

## Timing
- The edge that samples `start` moves the state to RUN; the next unstalled edge presents imem[0] with `if_valid`=1. This is one cycle of latency from RUN entry.
- Throughput: one instruction per unstalled cycle.
- Stall takes effect on the same edge it is sampled high. Outputs stay bit-identical across every stalled cycle.
- HALT on op 7: `if_valid` falls on the edge that samples that word, and `halted` rises on the same edge.
- HALT at the last address: the last instruction is emitted with `if_valid`=1 on the same edge that `halted` rises. `if_valid` clears on the following edge.
- Memory writes are visible to combinational read in the cycle after the write edge.

## Test plan
- Load ADD, ADDI(imm=5), SW, LW, SLL, HALT at addresses 0-5, then pulse `start`. Required: `if_opcode` sequence 0,1,2,3,4 with `if_pc` 0-4 and `if_valid`=1 for 5 consecutive cycles. Then `if_valid`=0 and `halted`=1; PC stays at 5.
- Same program with `stall` high for 3 cycles while `if_pc`=2. Required: outputs hold at pc 2 / SW for exactly 3 extra cycles, then LW at pc 3; no instruction is skipped or duplicated.
- Fill all 32 words with ADD and no HALT. Required: 32 valid outputs, pc 0-31, then `halted`=1 with PC=31. PC never wraps to 0.
- Assert `rst` while `if_pc`=3 in RUN. Required: the next cycle shows IDLE, `if_valid`=0, `if_pc`=0, `busy`=0. Memory still returns the original program after reload-free `start`.
- Assert `load_en` writing HALT to address 1 during RUN. Required: ignored, and the original word at 1 executes.
- Pulse `start` in HALT. Required: execution restarts and imem[0] is valid one cycle after RUN entry.
- Assert `start`+`load_en` (addr 0, SLL) together in IDLE. Required: the first fetched opcode is 4.
